// File: rtl/fb_pkg.sv
// Shared types and default parameters for the framebuffer write sequencer.
package fb_pkg;

    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned WRITE_GAP_DEF    = 8;
    localparam int unsigned FRAME_PIXELS_DEF = 76800;
    localparam int unsigned ACK_TIMEOUT_DEF  = 64;

    localparam int unsigned PIX_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTER = 3'd1,
        ARMED = 3'd2,
        PULSE = 3'd3,
        GAP   = 3'd4,
        EXIT  = 3'd5
    } state_t;

    // One buffered pixel: gray value plus start-of-frame marker.
    typedef struct packed {
        logic             first;
        logic [PIX_W-1:0] data;
    } pix_t;

    localparam int unsigned PIX_ENTRY_W = $bits(pix_t);

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pixels between upstream and the write FSM.
module pixel_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_next = cnt;
        if (push_ok && !pop_ok) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; flags registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt   <= cnt_next;
            full  <= (cnt_next == CNT_W'(DEPTH));
            empty <= (cnt_next == '0);
        end
    end

endmodule

// File: rtl/fb_write_sequencer.sv
// Sequences buffered pixels into paced write_data pulses for the framebuffer driver.
module fb_write_sequencer
    import fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int unsigned WRITE_GAP    = WRITE_GAP_DEF,
    parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixel_valid,
    input  logic [3:0] pixel_data,
    input  logic       pixel_first,
    output logic       pixel_ready,
    output logic       write_mode,
    output logic [3:0] write_data_in,
    output logic       reset_write_ptr,
    output logic       write_data,
    input  logic       wrote_data,
    output logic       busy,
    output logic       frame_done,
    output logic       err_timeout
);

    localparam int unsigned AW  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GW  = $clog2(WRITE_GAP + 1);
    localparam int unsigned PCW = $clog2(FRAME_PIXELS + 1);

    state_t          state;
    logic [AW-1:0]   ack_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            exit_cnt;
    logic [PCW-1:0]  pix_cnt;
    logic [PCW-1:0]  pix_cnt_next_c;
    logic            first_sel_c;
    logic            frame_cplt_c;
    logic            gap_last_c;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    pix_t            in_pix;
    pix_t            head_pix;

    assign in_pix      = '{first: pixel_first, data: pixel_data};
    assign pixel_ready = !fifo_full;
    assign fifo_push   = pixel_valid && !fifo_full;
    assign fifo_pop    = (state == ARMED) && !fifo_empty;

    pixel_fifo #(
        .WIDTH (PIX_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (in_pix),
        .head_c (head_pix),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Pixel count after the pixel being popped (ARMED) or pulsed (PULSE).
    always_comb begin
        first_sel_c  = (state == ARMED) ? head_pix.first : reset_write_ptr;
        frame_cplt_c = (pix_cnt == PCW'(FRAME_PIXELS));
        if (first_sel_c || frame_cplt_c) begin
            pix_cnt_next_c = PCW'(1);
        end else begin
            pix_cnt_next_c = pix_cnt + PCW'(1);
        end
        // PULSE + GAP + ARMED together span WRITE_GAP cycles between pulses.
        gap_last_c = (32'(gap_cnt) + 32'd3 >= WRITE_GAP);
    end

    // Write-mode sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ack_cnt         <= '0;
            gap_cnt         <= '0;
            exit_cnt        <= 1'b0;
            pix_cnt         <= '0;
            write_mode      <= 1'b0;
            write_data_in   <= '0;
            reset_write_ptr <= 1'b0;
            write_data      <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            write_data <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state      <= ENTER;
                        ack_cnt    <= '0;
                        write_mode <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ENTER: begin
                    if (wrote_data) begin
                        state <= ARMED;
                    end else if (ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        state       <= EXIT;
                        exit_cnt    <= 1'b0;
                        write_mode  <= 1'b0;
                        err_timeout <= 1'b1;
                    end else begin
                        ack_cnt <= ack_cnt + AW'(1);
                    end
                end
                ARMED: begin
                    if (!fifo_empty) begin
                        state           <= PULSE;
                        write_data_in   <= head_pix.data;
                        reset_write_ptr <= head_pix.first;
                        write_data      <= 1'b1;
                        frame_done      <= (pix_cnt_next_c == PCW'(FRAME_PIXELS));
                    end else if (frame_cplt_c) begin
                        state      <= EXIT;
                        exit_cnt   <= 1'b0;
                        write_mode <= 1'b0;
                    end
                end
                PULSE: begin
                    pix_cnt <= pix_cnt_next_c;
                    gap_cnt <= '0;
                    state   <= (WRITE_GAP > 2) ? GAP : ARMED;
                end
                GAP: begin
                    if (gap_last_c) begin
                        state <= ARMED;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                EXIT: begin
                    if (exit_cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        exit_cnt <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    write_mode <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
